// File: rtl/register_bank_wb.sv
// -----------------------------------------------------------------------------
// register_bank_wb
//
// Architectural register file and write-back scoreboard for the 20-bit
// pipelined processor. It receives the write-back stage outputs, serves two
// decode-stage read ports with same-cycle write-through bypass, and tracks
// in-flight destination writes so decode can be stalled on a read-after-write
// hazard.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears registers and counters
//   wb_enable    write-back strobe
//   wb_addr      write-back destination register
//   wb_data      write-back data
//   rd_addr_a    read port A index
//   rd_data_a    read port A data (combinational, bypasses wb_data)
//   rd_addr_b    read port B index
//   rd_data_b    read port B data (combinational, bypasses wb_data)
//   issue_valid  decode presents an instruction this cycle
//   issue_instr  instruction being issued
//                {opcode[19:16], dest[15:12], src1[11:8], src2[7:4], imm[3:0]}
//   issue_stall  instruction must not issue; decode holds it
//   busy_mask    bit r set while register r has an outstanding write
// -----------------------------------------------------------------------------
module register_bank_wb #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      wb_enable,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [DATA_W-1:0]         wb_data,

  input  logic [ADDR_W-1:0]         rd_addr_a,
  output logic [DATA_W-1:0]         rd_data_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic [DATA_W-1:0]         rd_data_b,

  input  logic                      issue_valid,
  input  logic [19:0]               issue_instr,
  output logic                      issue_stall,
  output logic [(1<<ADDR_W)-1:0]    busy_mask
);

  localparam int              NUM_REGS = 1 << ADDR_W;
  localparam logic [3:0]      OP_STORE = 4'b1100;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Fixed instruction format of the processor.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] dest;
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] imm;
  } instr_t;

  instr_t instr;
  assign instr = instr_t'(issue_instr);

  // The immediate field plays no part in hazard tracking.
  logic unused_imm;
  assign unused_imm = ^instr.imm;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt  [NUM_REGS];

  // ---------------------------------------------------------------------------
  // Per-register write-back decode and effective pending count
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] inc;
  logic [CNT_W-1:0]    pend_eff [NUM_REGS];

  logic is_store;
  logic accepted;

  assign is_store = (instr.opcode == OP_STORE);

  // NOTE: every signal assigned in an always_comb gets a default before any
  // conditional logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wb_hit = '0;
    dec    = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_eff[r] = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      wb_hit[r]   = wb_enable && (wb_addr == ADDR_W'(r));
      // A write-back to an idle register carries data only; it never counts
      // as a retirement, so neither the counter nor pend_eff can wrap below 0.
      dec[r]      = wb_hit[r] && (cnt[r] != '0);
      pend_eff[r] = cnt[r] - {{(CNT_W-1){1'b0}}, dec[r]};
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard check
  //   Sources (and the dest of a store, which is read as store data) must have
  //   no write outstanding once this cycle's retirement is accounted for.
  //   A writer only waits on its dest when that counter is already saturated.
  // ---------------------------------------------------------------------------
  logic src_hazard;
  logic dest_hazard;

  always_comb begin
    src_hazard  = (pend_eff[instr.src1] != '0) || (pend_eff[instr.src2] != '0);
    dest_hazard = is_store ? (pend_eff[instr.dest] != '0)
                           : (cnt[instr.dest] == CNT_MAX);
    issue_stall = issue_valid && (src_hazard || dest_hazard);
  end

  assign accepted = issue_valid && !issue_stall;

  always_comb begin
    inc = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r] = accepted && !is_store && (instr.dest == ADDR_W'(r));
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports with write-through bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (wb_enable && (wb_addr == rd_addr_a)) rd_data_a = wb_data;
    if (wb_enable && (wb_addr == rd_addr_b)) rd_data_b = wb_data;
  end

  // busy_mask is taken straight from the counter flops, so it shows the state
  // after the last edge and deliberately ignores the current write-back.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_mask[r] = (cnt[r] != '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  // NOTE: the register array is reset because software expects every
  // architectural register to read zero after reset; this keeps it in flops
  // rather than a RAM macro, which is acceptable at 16 entries.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_enable) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight write counters
  //   Simultaneous issue and retirement on the same register cancel out.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc[r] && !dec[r]) begin
          cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec[r] && !inc[r]) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_register_bank_wb.sv
// -----------------------------------------------------------------------------
// tb_register_bank_wb
//
// Directed bench for register_bank_wb. Stimulus drives one cycle of inputs
// shortly after each rising edge and pushes the hand-computed expected
// outputs for that cycle into a scoreboard queue; a monitor samples the DUT
// on the falling edge and pops/compares every queued expectation.
// -----------------------------------------------------------------------------
module tb_register_bank_wb;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_enable;
  logic [3:0]  wb_addr;
  logic [19:0] wb_data;
  logic [3:0]  rd_addr_a;
  logic [19:0] rd_data_a;
  logic [3:0]  rd_addr_b;
  logic [19:0] rd_data_b;
  logic        issue_valid;
  logic [19:0] issue_instr;
  logic        issue_stall;
  logic [15:0] busy_mask;

  register_bank_wb dut (
    .clock       (clock),
    .reset       (reset),
    .wb_enable   (wb_enable),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rd_addr_a   (rd_addr_a),
    .rd_data_a   (rd_data_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_b   (rd_data_b),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_stall (issue_stall),
    .busy_mask   (busy_mask)
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    bit          chk_data;
    logic [19:0] a;
    logic [19:0] b;
    logic        stall;
    logic [15:0] busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input string field,
                       input logic [19:0] actual, input logic [19:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, actual, required);
    end
  endtask

  // Monitor: sample away from the driving edge, drain every expectation.
  initial begin
    forever begin
      @(negedge clock);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        if (mon_e.chk_data) begin
          check(mon_e.name, "rd_data_a", rd_data_a, mon_e.a);
          check(mon_e.name, "rd_data_b", rd_data_b, mon_e.b);
        end
        check(mon_e.name, "issue_stall", 20'(issue_stall), 20'(mon_e.stall));
        check(mon_e.name, "busy_mask",   20'(busy_mask),   20'(mon_e.busy));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rst, input logic wbe, input logic [3:0] wba,
                       input logic [19:0] wbd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic iv,
                       input logic [19:0] ii);
    @(posedge clock);
    #1;
    reset       = rst;
    wb_enable   = wbe;
    wb_addr     = wba;
    wb_data     = wbd;
    rd_addr_a   = ra;
    rd_addr_b   = rb;
    issue_valid = iv;
    issue_instr = ii;
  endtask

  task automatic expect_all(input string name, input logic [19:0] a,
                            input logic [19:0] b, input logic s,
                            input logic [15:0] m);
    exp_t e;
    e.name = name; e.chk_data = 1'b1; e.a = a; e.b = b; e.stall = s; e.busy = m;
    sb.push_back(e);
  endtask

  task automatic expect_ctl(input string name, input logic s, input logic [15:0] m);
    exp_t e;
    e.name = name; e.chk_data = 1'b0; e.a = '0; e.b = '0; e.stall = s; e.busy = m;
    sb.push_back(e);
  endtask

  // Short aliases for the stimulus table below.
  task automatic idle(input logic [3:0] ra, input logic [3:0] rb);
    drive(1'b0, 1'b0, 4'd0, 20'h0, ra, rb, 1'b0, 20'h0);
  endtask

  task automatic issue(input logic [19:0] ii, input logic [3:0] ra, input logic [3:0] rb);
    drive(1'b0, 1'b0, 4'd0, 20'h0, ra, rb, 1'b1, ii);
  endtask

  task automatic wb(input logic [3:0] wba, input logic [19:0] wbd,
                    input logic [3:0] ra, input logic [3:0] rb);
    drive(1'b0, 1'b1, wba, wbd, ra, rb, 1'b0, 20'h0);
  endtask

  task automatic wb_issue(input logic [3:0] wba, input logic [19:0] wbd,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [19:0] ii);
    drive(1'b0, 1'b1, wba, wbd, ra, rb, 1'b1, ii);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; issue_valid = 1'b0; issue_instr = '0;

    // Reset: everything reads zero, nothing busy, no stall.
    drive(1'b1, 1'b0, 4'd0, 20'h0, 4'd0, 4'd8, 1'b0, 20'h0);
    expect_all("reset_hold", 20'h0, 20'h0, 1'b0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      idle(4'(i), 4'(i + 8));
      expect_all($sformatf("reset_read_r%0d_r%0d", i, i + 8), 20'h0, 20'h0, 1'b0, 16'h0000);
    end

    // Same-cycle bypass, then readback from the array on both ports.
    // A write-back to an idle register leaves its counter at zero.
    wb(4'd5, 20'hABCDE, 4'd5, 4'd6);
    expect_all("bypass_wr5", 20'hABCDE, 20'h0, 1'b0, 16'h0000);
    idle(4'd5, 4'd5);
    expect_all("readback_r5", 20'hABCDE, 20'hABCDE, 1'b0, 16'h0000);

    // RAW hazard: ADD r3<-r1,r2 then an op reading r3.
    issue(20'h03120, 4'd1, 4'd2);
    expect_ctl("raw_issue_add", 1'b0, 16'h0000);
    issue(20'h04300, 4'd3, 4'd0);
    expect_all("raw_stall_1", 20'h0, 20'h0, 1'b1, 16'h0008);
    issue(20'h04300, 4'd3, 4'd0);
    expect_all("raw_stall_2", 20'h0, 20'h0, 1'b1, 16'h0008);
    wb_issue(4'd3, 20'h33333, 4'd3, 4'd3, 20'h04300);
    expect_all("raw_retire", 20'h33333, 20'h33333, 1'b0, 16'h0008);
    idle(4'd3, 4'd4);
    expect_all("raw_after", 20'h33333, 20'h0, 1'b0, 16'h0010);
    wb(4'd4, 20'h44444, 4'd4, 4'd5);
    expect_all("drain_r4", 20'h44444, 20'hABCDE, 1'b0, 16'h0010);
    idle(4'd4, 4'd0);
    expect_all("drain_r4_after", 20'h44444, 20'h0, 1'b0, 16'h0000);

    // Saturation of r7's counter.
    issue(20'h07000, 4'd0, 4'd0);
    expect_ctl("sat_issue_1", 1'b0, 16'h0000);
    issue(20'h07000, 4'd0, 4'd0);
    expect_ctl("sat_issue_2", 1'b0, 16'h0080);
    issue(20'h07000, 4'd0, 4'd0);
    expect_ctl("sat_issue_3", 1'b0, 16'h0080);
    issue(20'h07000, 4'd0, 4'd0);
    expect_ctl("sat_stall", 1'b1, 16'h0080);
    wb(4'd7, 20'h77771, 4'd7, 4'd0);                  // 3 -> 2
    expect_all("sat_wb1", 20'h77771, 20'h0, 1'b0, 16'h0080);
    wb_issue(4'd7, 20'h77772, 4'd7, 4'd0, 20'h07000); // inc+dec: stays 2
    expect_all("sat_both", 20'h77772, 20'h0, 1'b0, 16'h0080);
    issue(20'h07000, 4'd7, 4'd0);                     // 2 -> 3, accepted
    expect_all("sat_refill", 20'h77772, 20'h0, 1'b0, 16'h0080);
    issue(20'h07000, 4'd7, 4'd0);                     // saturated again
    expect_ctl("sat_full_again", 1'b1, 16'h0080);
    for (int i = 1; i <= 3; i++) begin
      wb(4'd7, 20'h70000 + 20'(i), 4'd7, 4'd0);
      expect_all($sformatf("sat_drain_%0d", i), 20'h70000 + 20'(i), 20'h0, 1'b0, 16'h0080);
    end
    idle(4'd7, 4'd0);
    expect_all("sat_drained", 20'h70003, 20'h0, 1'b0, 16'h0000);

    // Stores read dest as a source and never mark it busy.
    issue(20'h06000, 4'd0, 4'd0);
    expect_ctl("store_prep_r6", 1'b0, 16'h0000);
    issue(20'hC6100, 4'd6, 4'd1);
    expect_ctl("store_wait_dest", 1'b1, 16'h0040);
    wb_issue(4'd6, 20'h66666, 4'd6, 4'd1, 20'hC6100);
    expect_all("store_accept", 20'h66666, 20'h0, 1'b0, 16'h0040);
    idle(4'd6, 4'd0);
    expect_all("store_no_inc", 20'h66666, 20'h0, 1'b0, 16'h0000);
    issue(20'hC5100, 4'd5, 4'd1);
    expect_all("store_free", 20'hABCDE, 20'h0, 1'b0, 16'h0000);
    idle(4'd5, 4'd0);
    expect_ctl("store_free_after", 1'b0, 16'h0000);

    // Reset with writes in flight and a simultaneous write-back.
    wb(4'd2, 20'h22222, 4'd2, 4'd0);
    expect_all("pre_reset_wr2", 20'h22222, 20'h0, 1'b0, 16'h0000);
    issue(20'h02000, 4'd2, 4'd0);
    expect_ctl("pre_reset_issue_r2", 1'b0, 16'h0000);
    issue(20'h09000, 4'd2, 4'd0);
    expect_ctl("pre_reset_issue_r9", 1'b0, 16'h0004);
    drive(1'b1, 1'b1, 4'd2, 20'h12345, 4'd2, 4'd9, 1'b1, 20'h0A000);
    expect_ctl("reset_inflight_pre", 1'b0, 16'h0204);
    idle(4'd2, 4'd9);
    expect_all("reset_inflight_post", 20'h0, 20'h0, 1'b0, 16'h0000);
    idle(4'd5, 4'd3);
    expect_all("reset_cleared_r5_r3", 20'h0, 20'h0, 1'b0, 16'h0000);

    @(negedge clock);
    #1;
    check("scoreboard", "pending_entries", 20'(sb.size()), 20'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
